// File: rtl/param_counting_sort.sv
// param_counting_sort: NUM x WIDTH-bit counting sorter with input capture,
// busy/valid status and the level start/clear handshake of the fixed sorter.
// Ports: clk_i, rst_i (sync, active high), start_clear_i, nums_i,
//        desc_i (only with PCS_DESCEND_EN), busy_o, valid_o, sorted_nums_o.
// Slot k of nums_i / sorted_nums_o is [k*WIDTH +: WIDTH].
// Optional feature macro: PCS_DESCEND_EN adds run-time descending order.
module param_counting_sort #(
    parameter int NUM   = 8,
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_clear_i,
    input  logic [NUM*WIDTH-1:0] nums_i,
`ifdef PCS_DESCEND_EN
    input  logic                 desc_i,
`endif
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [NUM*WIDTH-1:0] sorted_nums_o
);

    localparam int B  = 1 << WIDTH;
    localparam int CW = $clog2(NUM + 1);
    localparam int IW = $clog2(NUM);
    localparam int NW = NUM * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SORT,
        DONE
    } state_e;

    state_e            state_q;
    logic [NW-1:0]     cap_q;
    logic [NW-1:0]     sorted_q;
    logic [CW-1:0]     cnt_q [B];
    logic [IW-1:0]     idx_q;
    logic [WIDTH-1:0]  ptr_q;
    logic              busy_q;
    logic              valid_q;

    logic [WIDTH-1:0]  elem_d;
    logic [WIDTH-1:0]  ptr_init_d;
    logic [WIDTH-1:0]  ptr_step_d;
    logic              clear_d;

`ifdef PCS_DESCEND_EN
    logic              desc_q;

    assign ptr_init_d = desc_q ? WIDTH'(B - 1) : '0;
    assign ptr_step_d = desc_q ? ptr_q - WIDTH'(1)
                               : ptr_q + WIDTH'(1);
`else
    assign ptr_init_d = '0;
    assign ptr_step_d = ptr_q + WIDTH'(1);
`endif

    // During COUNT the slot index walks the captured word.
    assign elem_d  = cap_q[idx_q*WIDTH +: WIDTH];
    // Dropping start in DONE clears everything exactly like reset.
    assign clear_d = rst_i || (state_q == DONE && !start_clear_i);

    always_ff @(posedge clk_i) begin
        if (clear_d) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            sorted_q <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            for (int b = 0; b < B; b++) begin
                cnt_q[b] <= '0;
            end
`ifdef PCS_DESCEND_EN
            desc_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_clear_i) begin
                        cap_q   <= nums_i;
`ifdef PCS_DESCEND_EN
                        desc_q  <= desc_i;
`endif
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    cnt_q[elem_d] <= cnt_q[elem_d] + CW'(1);
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        ptr_q   <= ptr_init_d;
                        state_q <= SORT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                SORT: begin
                    if (cnt_q[ptr_q] != '0) begin
                        sorted_q[idx_q*WIDTH +: WIDTH] <= ptr_q;
                        cnt_q[ptr_q] <= cnt_q[ptr_q] - CW'(1);
                        // Finish on the last write; never scan the
                        // remaining empty buckets.
                        if (idx_q == LAST) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        ptr_q <= ptr_step_d;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign valid_o       = valid_q;
    assign sorted_nums_o = sorted_q;

endmodule

// File: doc/param_counting_sort.md
# param_counting_sort

Parametrised counting-sort engine: the next generation of the team's 8×4-bit sorter, generalised to NUM elements of WIDTH bits, with input capture at start and a busy indicator. It sits between the number-entry front end and the result display/readout and uses the same start/clear handshake, so it drops in wherever the fixed-size sorter was used. An optional compile-time mode adds run-time selectable descending order.

## Interface
Parameters:
- NUM, 8, number of elements sorted; legal range 2..16.
- WIDTH, 4, bits per element; legal range 1..8; bucket count B = 2^WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_clear_i  input  1  level handshake: high in IDLE starts a sort; low in DONE clears.
- nums_i  input  NUM*WIDTH  packed unsorted elements; slot k = nums_i[k*WIDTH +: WIDTH].
- desc_i  input  1  present only with PCS_DESCEND_EN; 1 selects descending order.
- busy_o  output  1  high in COUNT and SORT.
- valid_o  output  1  high in DONE; result stable.
- sorted_nums_o  output  NUM*WIDTH  sorted result in the same slot packing.

## Operation
- States: IDLE, COUNT, SORT, DONE.
- Reset (any state, including mid-operation): state IDLE; valid_o=0, busy_o=0, sorted_nums_o=0; all bucket counts, slot index, bucket pointer and capture register = 0.
- IDLE: start_clear_i=1 at an edge captures nums_i (and desc_i) into an internal register and moves to COUNT. After capture, changes on nums_i/desc_i have no effect until the next start.
- COUNT: one captured element per cycle, slot 0 first; its bucket count increments by 1. Counts are $clog2(NUM+1) bits wide and cannot overflow. After slot NUM-1, go to SORT. The bucket pointer starts at 0 (ascending) or B-1 (descending).
- SORT, each cycle:
  - If count[ptr] ≠ 0: write ptr into output slot idx, decrement count[ptr], increment idx.
  - If count[ptr] = 0: step ptr by +1 (ascending) or −1 (descending).
  - The cycle that writes slot NUM-1 moves to DONE and sets valid_o. No scan past the last occupied bucket is done.
- start_clear_i is ignored in COUNT and SORT; dropping it mid-sort does not abort.
- DONE: outputs hold while start_clear_i=1. When start_clear_i=0, the next edge returns to IDLE and clears all state as on reset.
- Ascending result: slot 0 holds the smallest value. Descending result: slot 0 holds the largest. Duplicates occupy consecutive slots.

## Timing
- Edge S samples start in IDLE. COUNT occupies the following NUM edges. SORT occupies the next NUM + D edges.
  - Ascending: D = maximum element value.
  - Descending: D = (B-1) − minimum element value.
- valid_o is first high after edge S + 2·NUM + D. Worst case is 2·NUM + B − 1 cycles.
- busy_o is high from edge S+1 until the edge that sets valid_o; busy_o and valid_o are never high together.
- sorted_nums_o slots update individually during SORT. The value is only defined while valid_o=1.
- Clear: start_clear_i=0 sampled in DONE → valid_o=0 and sorted_nums_o=0 after that edge. A new start is accepted no earlier than the following edge.

## Configuration
- PCS_DESCEND_EN defined:
  - desc_i port exists and is sampled at start.
  - Bucket pointer direction and initial value follow desc_i.
- PCS_DESCEND_EN undefined:
  - No desc_i port.
  - Ascending order only; the descending pointer logic is not built.

## Test plan
- NUM=8, WIDTH=4, nums_i=32'h7316_2504 → sorted_nums_o=32'h7654_3210; valid_o after 23 cycles; busy_o high for the 22 cycles before that.
- Duplicates and extremes: 32'hFFFF_FFFF → 32'hFFFF_FFFF at 31 cycles; 32'h0000_0000 → 32'h0 at 16 cycles; 32'h0F0F_0F0F → 32'hFFFF_0000.
- PCS_DESCEND_EN with desc_i=1, nums_i=32'h7316_2504 → 32'h0123_4567 at 31 cycles. Toggling desc_i and nums_i after the start edge does not change the result.
- Handshake: hold start_clear_i=1 for 5 cycles in DONE → outputs unchanged. Drop it → valid_o=0 and sorted_nums_o=0 after one edge. A new start then sorts fresh data correctly, with no stale counts.
- rst_i=1 for one cycle mid-SORT → next cycle IDLE with all outputs 0. Pulsing start_clear_i low during COUNT does not abort the sort.
- NUM=4, WIDTH=2, nums_i=8'b10_11_00_10 (slots 2,0,3,2) → 8'b11_10_10_00, valid_o at 2·4+3=11 cycles.
